// File: rtl/enm_fire_sched_if.sv
// Enemy fire scheduler bus: round control, enemy positions in, bullet slots and grants out.
interface enm_fire_sched_if;
  logic       gamestart;
  logic       freeze;
  logic [3:0] enm_alive;
  logic [9:0] enmx1, enmx2, enmx3, enmx4;
  logic [9:0] enmy1, enmy2, enmy3, enmy4;
  logic [1:0] bhit;
  logic [3:0] fire_grant;
  logic [1:0] eb_valid;
  logic [9:0] ebx0, eby0, ebx1, eby1;
  logic [1:0] sched_state;

  modport master (
    output gamestart, freeze, enm_alive,
    output enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4, bhit,
    input  fire_grant, eb_valid, ebx0, eby0, ebx1, eby1, sched_state
  );

  modport slave (
    input  gamestart, freeze, enm_alive,
    input  enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4, bhit,
    output fire_grant, eb_valid, ebx0, eby0, ebx1, eby1, sched_state
  );
endinterface

// File: rtl/enm_fire_sched.sv
// Enemy fire scheduler: paces round-robin enemy shots into two bullet slots and
// moves live bullets down the screen until they retire or hit the player.
module enm_fire_sched #(
  parameter int unsigned FIRE_IVL = 40,
  parameter int unsigned EB_SPEED = 4,
  parameter int unsigned EB_YMAX  = 480
) (
  input  logic            clk22,
  input  logic            rst,
  enm_fire_sched_if.slave bus
);

  localparam int unsigned IVL_W = 6;
  localparam int unsigned POS_W = 10;
  localparam int unsigned CMP_W = 11;
  localparam int unsigned N_ENM = 4;
  localparam int unsigned N_EB  = 2;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IVL_W-1:0] IVL_RELOAD = IVL_W'(FIRE_IVL - 1);
  localparam logic [POS_W-1:0] X_OFS      = POS_W'(8);
  localparam logic [POS_W-1:0] Y_OFS      = POS_W'(16);
  localparam logic [POS_W-1:0] Y_STEP     = POS_W'(EB_SPEED);
  localparam logic [CMP_W-1:0] Y_STEP_W   = CMP_W'(EB_SPEED);
  localparam logic [CMP_W-1:0] Y_LIMIT_W  = CMP_W'(EB_YMAX);

  logic [1:0]       state_q, state_d;
  logic [IVL_W-1:0] ivl_cnt_q, ivl_cnt_d;
  logic [1:0]       rr_q, rr_d;
  logic [N_ENM-1:0] grant_q, grant_d;
  logic [N_EB-1:0]  valid_q, valid_d;
  logic [POS_W-1:0] ebx_q [N_EB];
  logic [POS_W-1:0] ebx_d [N_EB];
  logic [POS_W-1:0] eby_q [N_EB];
  logic [POS_W-1:0] eby_d [N_EB];

  logic             enm_found;
  logic [1:0]       enm_pick;
  logic [1:0]       enm_idx;
  logic             slot_free;
  logic             slot_pick;
  logic             fire;
  logic [POS_W-1:0] pick_x, pick_y;
  logic             any_alive;

  // Next-state: FSM, interval pacing, round-robin pick and bullet slot update
  always_comb begin
    state_d   = state_q;
    ivl_cnt_d = ivl_cnt_q;
    rr_d      = rr_q;
    grant_d   = '0;
    valid_d   = valid_q;
    ebx_d     = ebx_q;
    eby_d     = eby_q;
    enm_found = 1'b0;
    enm_pick  = rr_q;
    enm_idx   = rr_q;
    slot_free = 1'b0;
    slot_pick = 1'b0;
    pick_x    = '0;
    pick_y    = '0;
    any_alive = (bus.enm_alive != '0);

    for (int i = 0; i < N_ENM; i++) begin
      enm_idx = rr_q + 2'(i);
      if (!enm_found && bus.enm_alive[enm_idx]) begin
        enm_found = 1'b1;
        enm_pick  = enm_idx;
      end
    end

    case (enm_pick)
      2'd0:    begin pick_x = bus.enmx1; pick_y = bus.enmy1; end
      2'd1:    begin pick_x = bus.enmx2; pick_y = bus.enmy2; end
      2'd2:    begin pick_x = bus.enmx3; pick_y = bus.enmy3; end
      default: begin pick_x = bus.enmx4; pick_y = bus.enmy4; end
    endcase

    // Free slots are judged on registered valid, so a slot freed this tick waits a tick
    if (!valid_q[0]) begin
      slot_free = 1'b1;
      slot_pick = 1'b0;
    end else if (!valid_q[1]) begin
      slot_free = 1'b1;
      slot_pick = 1'b1;
    end

    fire = (state_q == ST_RUN) && (ivl_cnt_q == '0) && slot_free && enm_found;

    case (state_q)
      ST_WAIT:  if (any_alive) state_d = ST_RUN;
      ST_RUN:   if (!any_alive) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (any_alive)              state_d = ST_RUN;
        else if (valid_q == '0)     state_d = ST_WAIT;
      end
      default:  state_d = ST_WAIT;
    endcase

    if (state_q == ST_RUN) begin
      if (fire)                  ivl_cnt_d = IVL_RELOAD;
      else if (ivl_cnt_q != '0)  ivl_cnt_d = ivl_cnt_q - IVL_W'(1);
    end

    // Hits take priority over movement; retirement compare is one bit wider to avoid wrap
    for (int k = 0; k < N_EB; k++) begin
      if (valid_q[k]) begin
        if (bus.bhit[k] || ({1'b0, eby_q[k]} + Y_STEP_W >= Y_LIMIT_W)) begin
          valid_d[k] = 1'b0;
          ebx_d[k]   = '0;
          eby_d[k]   = '0;
        end else begin
          eby_d[k]   = eby_q[k] + Y_STEP;
        end
      end
    end

    if (fire) begin
      grant_d[enm_pick]  = 1'b1;
      rr_d               = enm_pick + 2'd1;
      valid_d[slot_pick] = 1'b1;
      ebx_d[slot_pick]   = pick_x + X_OFS;
      eby_d[slot_pick]   = pick_y + Y_OFS;
    end
  end

  // State registers: reset/gamestart win over freeze; freeze holds all but the grant pulse
  always_ff @(posedge clk22) begin
    if (rst || bus.gamestart) begin
      state_q   <= ST_WAIT;
      ivl_cnt_q <= IVL_RELOAD;
      rr_q      <= '0;
      grant_q   <= '0;
      valid_q   <= '0;
      for (int k = 0; k < N_EB; k++) begin
        ebx_q[k] <= '0;
        eby_q[k] <= '0;
      end
    end else if (bus.freeze) begin
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      ivl_cnt_q <= ivl_cnt_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      for (int k = 0; k < N_EB; k++) begin
        ebx_q[k] <= ebx_d[k];
        eby_q[k] <= eby_d[k];
      end
    end
  end

  assign bus.fire_grant  = grant_q;
  assign bus.eb_valid    = valid_q;
  assign bus.ebx0        = ebx_q[0];
  assign bus.eby0        = eby_q[0];
  assign bus.ebx1        = ebx_q[1];
  assign bus.eby1        = eby_q[1];
  assign bus.sched_state = state_q;

endmodule

// File: tb/tb_enm_fire_sched.sv
// Directed bench for enm_fire_sched: pacing, round-robin, slot contention, retirement, drain and freeze.
module tb_enm_fire_sched;

  logic clk22 = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] seen;

  enm_fire_sched_if bus();

  enm_fire_sched #(
    .FIRE_IVL (40),
    .EB_SPEED (4),
    .EB_YMAX  (480)
  ) dut (
    .clk22 (clk22),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk22 = ~clk22;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle after the update
  task automatic tick(input int n);
    repeat (n) @(negedge clk22);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk22);
      seen = seen | bus.fire_grant;
    end
  endtask

  task automatic set_enm(input int idx, input logic [9:0] x, input logic [9:0] y);
    case (idx)
      1: begin bus.enmx1 = x; bus.enmy1 = y; end
      2: begin bus.enmx2 = x; bus.enmy2 = y; end
      3: begin bus.enmx3 = x; bus.enmy3 = y; end
      default: begin bus.enmx4 = x; bus.enmy4 = y; end
    endcase
  endtask

  task automatic do_reset(input logic [3:0] alive);
    rst = 1'b1;
    bus.enm_alive = alive;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.gamestart = 1'b0;
    bus.freeze    = 1'b0;
    bus.bhit      = 2'b00;
    bus.enm_alive = 4'b0000;
    set_enm(1, 10'd40,  10'd40);
    set_enm(2, 10'd100, 10'd400);
    set_enm(3, 10'd200, 10'd60);
    set_enm(4, 10'd300, 10'd400);

    // First grant latency after reset release
    rst = 1'b1;
    bus.enm_alive = 4'b1111;
    tick(2);
    check_eq("rst_state", 32'(bus.sched_state), 32'd0);
    check_eq("rst_valid", 32'(bus.eb_valid), 32'd0);
    check_eq("rst_grant", 32'(bus.fire_grant), 32'd0);
    check_eq("rst_eby0",  32'(bus.eby0), 32'd0);
    check_eq("rst_ivl",   32'(dut.ivl_cnt_q), 32'd39);
    rst = 1'b0;
    tick(1);
    check_eq("e1_state", 32'(bus.sched_state), 32'd1);
    check_eq("e1_ivl",   32'(dut.ivl_cnt_q), 32'd39);
    tick(39);
    check_eq("e40_ivl",   32'(dut.ivl_cnt_q), 32'd0);
    check_eq("e40_grant", 32'(bus.fire_grant), 32'd0);
    tick(1);
    check_eq("e41_grant", 32'(bus.fire_grant), 32'b0001);
    check_eq("e41_ebx0",  32'(bus.ebx0), 32'd48);
    check_eq("e41_eby0",  32'(bus.eby0), 32'd56);
    check_eq("e41_valid", 32'(bus.eb_valid), 32'b01);
    check_eq("e41_ivl",   32'(dut.ivl_cnt_q), 32'd39);
    tick(1);
    check_eq("e42_eby0",  32'(bus.eby0), 32'd60);
    check_eq("e42_grant", 32'(bus.fire_grant), 32'd0);

    // Retirement boundary at the bottom of the screen
    set_enm(1, 10'd40, 10'd460);
    do_reset(4'b0001);
    tick(41);
    check_eq("y476_grant", 32'(bus.fire_grant), 32'b0001);
    check_eq("y476_eby0",  32'(bus.eby0), 32'd476);
    tick(1);
    check_eq("y476_valid", 32'(bus.eb_valid), 32'd0);
    check_eq("y476_ebx0",  32'(bus.ebx0), 32'd0);
    check_eq("y476_eby0z", 32'(bus.eby0), 32'd0);
    set_enm(1, 10'd40, 10'd459);
    tick(39);
    check_eq("y475_grant", 32'(bus.fire_grant), 32'b0001);
    check_eq("y475_eby0",  32'(bus.eby0), 32'd475);
    tick(1);
    check_eq("y479_eby0",  32'(bus.eby0), 32'd479);
    check_eq("y479_valid", 32'(bus.eb_valid), 32'b01);
    tick(1);
    check_eq("y483_valid", 32'(bus.eb_valid), 32'd0);

    // Round-robin over enemies 2 and 4 only
    do_reset(4'b1010);
    tick(41);
    check_eq("rr1_grant", 32'(bus.fire_grant), 32'b0010);
    check_eq("rr1_ebx0",  32'(bus.ebx0), 32'd108);
    check_eq("rr1_eby0",  32'(bus.eby0), 32'd416);
    seen = '0;
    run(39);
    check_eq("rr_gap1", 32'(seen), 32'd0);
    tick(1);
    check_eq("rr2_grant", 32'(bus.fire_grant), 32'b1000);
    check_eq("rr2_ebx0",  32'(bus.ebx0), 32'd308);
    check_eq("rr2_valid", 32'(bus.eb_valid), 32'b01);
    run(39);
    check_eq("rr_gap2", 32'(seen), 32'd0);
    tick(1);
    check_eq("rr3_grant", 32'(bus.fire_grant), 32'b0010);
    check_eq("rr3_ebx0",  32'(bus.ebx0), 32'd108);

    // Both slots busy: grant stalls, then a hit frees slot 0
    set_enm(1, 10'd40, 10'd40);
    do_reset(4'b0001);
    tick(81);
    check_eq("full_grant81", 32'(bus.fire_grant), 32'b0001);
    check_eq("full_ebx1",    32'(bus.ebx1), 32'd48);
    check_eq("full_eby1",    32'(bus.eby1), 32'd56);
    check_eq("full_eby0",    32'(bus.eby0), 32'd216);
    tick(40);
    check_eq("stall_grant", 32'(bus.fire_grant), 32'd0);
    check_eq("stall_ivl",   32'(dut.ivl_cnt_q), 32'd0);
    check_eq("stall_valid", 32'(bus.eb_valid), 32'b11);
    tick(1);
    check_eq("stall2_grant", 32'(bus.fire_grant), 32'd0);
    check_eq("stall2_ivl",   32'(dut.ivl_cnt_q), 32'd0);
    bus.bhit = 2'b01;
    tick(1);
    check_eq("hit_valid", 32'(bus.eb_valid), 32'b10);
    check_eq("hit_eby0",  32'(bus.eby0), 32'd0);
    check_eq("hit_grant", 32'(bus.fire_grant), 32'd0);
    bus.bhit = 2'b00;
    tick(1);
    check_eq("refire_grant", 32'(bus.fire_grant), 32'b0001);
    check_eq("refire_valid", 32'(bus.eb_valid), 32'b11);
    check_eq("refire_eby0",  32'(bus.eby0), 32'd56);
    check_eq("refire_ivl",   32'(dut.ivl_cnt_q), 32'd39);

    // Drain: bullets keep flying with no enemies, then back to WAIT
    bus.enm_alive = 4'b0000;
    tick(1);
    check_eq("drain_state", 32'(bus.sched_state), 32'd2);
    check_eq("drain_eby0",  32'(bus.eby0), 32'd60);
    check_eq("drain_eby1",  32'(bus.eby1), 32'd232);
    seen = '0;
    run(25);
    check_eq("drain_state2", 32'(bus.sched_state), 32'd2);
    bus.enm_alive = 4'b0100;
    tick(1);
    check_eq("drain_to_run", 32'(bus.sched_state), 32'd1);
    bus.enm_alive = 4'b0000;
    tick(1);
    check_eq("run_to_drain", 32'(bus.sched_state), 32'd2);
    run(77);
    check_eq("drain_nogrant", 32'(seen), 32'd0);
    check_eq("drain_valid",   32'(bus.eb_valid), 32'b01);
    check_eq("drain_eby0_476", 32'(bus.eby0), 32'd476);
    tick(1);
    check_eq("drain_empty", 32'(bus.eb_valid), 32'd0);
    check_eq("drain_hold",  32'(bus.sched_state), 32'd2);
    tick(1);
    check_eq("drain_wait",  32'(bus.sched_state), 32'd0);

    // Freeze holds everything; gamestart still resets through it
    do_reset(4'b1111);
    tick(46);
    check_eq("pre_frz_eby0", 32'(bus.eby0), 32'd76);
    check_eq("pre_frz_ivl",  32'(dut.ivl_cnt_q), 32'd34);
    bus.freeze = 1'b1;
    tick(10);
    check_eq("frz_eby0",  32'(bus.eby0), 32'd76);
    check_eq("frz_ebx0",  32'(bus.ebx0), 32'd48);
    check_eq("frz_ivl",   32'(dut.ivl_cnt_q), 32'd34);
    check_eq("frz_state", 32'(bus.sched_state), 32'd1);
    check_eq("frz_valid", 32'(bus.eb_valid), 32'b01);
    check_eq("frz_grant", 32'(bus.fire_grant), 32'd0);
    bus.gamestart = 1'b1;
    tick(1);
    check_eq("gs_state", 32'(bus.sched_state), 32'd0);
    check_eq("gs_valid", 32'(bus.eb_valid), 32'd0);
    check_eq("gs_eby0",  32'(bus.eby0), 32'd0);
    check_eq("gs_ivl",   32'(dut.ivl_cnt_q), 32'd39);
    check_eq("gs_grant", 32'(bus.fire_grant), 32'd0);
    bus.gamestart = 1'b0;
    bus.freeze    = 1'b0;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
